timer_sequencer: RTL and testbench

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_pkg.sv | 53 +++++
 rtl/timer_sequencer.sv | 136 +++++++++++++
 tb/tb_timer_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit layout, bus command type and sequencer states
// for the timer peripheral.
package timer_pkg;

    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_STATUS    = 4'd1;
    localparam logic [3:0] ADDR_COUNT     = 4'd2;
    localparam logic [3:0] ADDR_CMP_1     = 4'd3;
    localparam logic [3:0] ADDR_CMP_0     = 4'd4;
    localparam logic [3:0] ADDR_COUNT_MIN = 4'd5;
    localparam logic [3:0] ADDR_COUNT_MAX = 4'd6;

    localparam int CTRL_CMP1_IE = 7;
    localparam int CTRL_CMP0_IE = 6;
    localparam int CTRL_CLK_SEL = 5;
    localparam int CTRL_MODE    = 4;
    localparam int CTRL_START   = 3;
    localparam int CTRL_PSC_MSB = 2;
    localparam int CTRL_PSC_LSB = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_STOP,
        S_WR_MIN,
        S_WR_MAX,
        S_WR_CMP0,
        S_WR_CMP1,
        S_RUN,
        S_MONITOR,
        S_CLEAR
    } state_t;

    typedef struct packed {
        logic       enable;
        logic       write_enable;
        logic [3:0] address;
    } bus_cmd_t;

    // CTRL image with the START bit forced; the START bit of the request is ignored.
    function automatic logic [7:0] ctrl_image(input logic [7:0] ctrl, input logic start);
        return {ctrl[CTRL_CMP1_IE], ctrl[CTRL_CMP0_IE], ctrl[CTRL_CLK_SEL], ctrl[CTRL_MODE],
                start, ctrl[CTRL_PSC_MSB:CTRL_PSC_LSB]};
    endfunction

    function automatic bus_cmd_t bus_write(input logic [3:0] addr);
        return '{enable: 1'b1, write_enable: 1'b1, address: addr};
    endfunction

    function automatic bus_cmd_t bus_read(input logic [3:0] addr);
        return '{enable: 1'b1, write_enable: 1'b0, address: addr};
    endfunction

endpackage

// File: rtl/timer_sequencer.sv
// Programs a timer peripheral over its register bus, then polls STATUS and
// acknowledges enabled compare flags until stopped or reconfigured.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int COUNTER_BIT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [7:0]                   cfg_ctrl,
    input  logic [COUNTER_BIT_WIDTH-1:0] cfg_min,
    input  logic [COUNTER_BIT_WIDTH-1:0] cfg_max,
    input  logic [COUNTER_BIT_WIDTH-1:0] cfg_cmp_0,
    input  logic [COUNTER_BIT_WIDTH-1:0] cfg_cmp_1,
    input  logic                         stop_req,
    output logic                         busy,
    output logic                         cfg_done,
    output logic                         cfg_error,
    output logic                         cmp_0_event,
    output logic                         cmp_1_event,
    output logic                         enable,
    output logic                         write_enable,
    output logic [3:0]                   address,
    output logic [COUNTER_BIT_WIDTH-1:0] write_data,
    input  logic [COUNTER_BIT_WIDTH-1:0] read_data
);

    localparam int W = COUNTER_BIT_WIDTH;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     ctrl_q;
    logic [7:0]     ctrl_nxt;
    logic [W-1:0]   min_q;
    logic [W-1:0]   max_q;
    logic [W-1:0]   cmp0_q;
    logic [W-1:0]   cmp1_q;
    logic           stop_q;
    logic           accept;
    logic           cfg_bad;
    logic [1:0]     pending;
    bus_cmd_t       bus_nxt;
    logic [W-1:0]   data_nxt;
    logic           unused_read_data;

    assign cfg_ready = ~rst & ~stop_req & ((state == S_IDLE) | (state == S_MONITOR));
    assign accept    = cfg_valid & cfg_ready;
    assign cfg_bad   = (cfg_min >= cfg_max);
    assign pending   = {read_data[CTRL_CMP1_IE] & ctrl_q[CTRL_CMP1_IE],
                        read_data[CTRL_CMP0_IE] & ctrl_q[CTRL_CMP0_IE]};
    assign unused_read_data = ^read_data;

    // stop_req outranks a new request, which outranks pending compare flags.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (accept && !cfg_bad) state_nxt = S_STOP;
            S_STOP:    state_nxt = stop_q ? S_IDLE : S_WR_MIN;
            S_WR_MIN:  state_nxt = S_WR_MAX;
            S_WR_MAX:  state_nxt = S_WR_CMP0;
            S_WR_CMP0: state_nxt = S_WR_CMP1;
            S_WR_CMP1: state_nxt = S_RUN;
            S_RUN:     state_nxt = S_MONITOR;
            S_MONITOR: begin
                if (stop_req)             state_nxt = S_STOP;
                else if (accept)          state_nxt = cfg_bad ? S_IDLE : S_STOP;
                else if (pending != 2'b0) state_nxt = S_CLEAR;
            end
            S_CLEAR:   state_nxt = S_MONITOR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The STOP write of a fresh sequence uses the CTRL image being latched this edge.
    always_comb begin
        ctrl_nxt = accept ? cfg_ctrl : ctrl_q;
        bus_nxt  = '0;
        data_nxt = '0;
        unique case (state_nxt)
            S_STOP:    begin bus_nxt = bus_write(ADDR_CTRL);      data_nxt = W'(ctrl_image(ctrl_nxt, 1'b0)); end
            S_WR_MIN:  begin bus_nxt = bus_write(ADDR_COUNT_MIN); data_nxt = min_q;  end
            S_WR_MAX:  begin bus_nxt = bus_write(ADDR_COUNT_MAX); data_nxt = max_q;  end
            S_WR_CMP0: begin bus_nxt = bus_write(ADDR_CMP_0);     data_nxt = cmp0_q; end
            S_WR_CMP1: begin bus_nxt = bus_write(ADDR_CMP_1);     data_nxt = cmp1_q; end
            S_RUN:     begin bus_nxt = bus_write(ADDR_CTRL);      data_nxt = W'(ctrl_image(ctrl_q, 1'b1)); end
            S_MONITOR: bus_nxt = bus_read(ADDR_STATUS);
            S_CLEAR:   begin bus_nxt = bus_write(ADDR_STATUS);    data_nxt = W'({pending, 6'b0}); end
            default:   bus_nxt = '0;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // sees the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ctrl_q       <= '0;
            min_q        <= '0;
            max_q        <= '0;
            cmp0_q       <= '0;
            cmp1_q       <= '0;
            stop_q       <= 1'b0;
            busy         <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            cmp_0_event  <= 1'b0;
            cmp_1_event  <= 1'b0;
            enable       <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            write_data   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ctrl_q <= cfg_ctrl;
                min_q  <= cfg_min;
                max_q  <= cfg_max;
                cmp0_q <= cfg_cmp_0;
                cmp1_q <= cfg_cmp_1;
            end
            stop_q       <= (state == S_MONITOR) && stop_req;
            busy         <= !(state_nxt inside {S_IDLE, S_MONITOR});
            cfg_done     <= (state == S_RUN);
            cfg_error    <= accept && cfg_bad;
            cmp_1_event  <= (state_nxt == S_CLEAR) && pending[1];
            cmp_0_event  <= (state_nxt == S_CLEAR) && pending[0];
            enable       <= bus_nxt.enable;
            write_enable <= bus_nxt.write_enable;
            address      <= bus_nxt.address;
            write_data   <= data_nxt;
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: per-cycle vector table with a
// scoreboard queue, followed by hand-written latency and error sequences.
module tb_timer_sequencer;

    localparam int W  = 12;
    localparam int OW = 12 + W;

    localparam logic [7:0] F_RDY  = 8'h80;
    localparam logic [7:0] F_BUSY = 8'h40;
    localparam logic [7:0] F_DONE = 8'h20;
    localparam logic [7:0] F_ERR  = 8'h10;
    localparam logic [7:0] F_E1   = 8'h08;
    localparam logic [7:0] F_E0   = 8'h04;
    localparam logic [7:0] F_EN   = 8'h02;
    localparam logic [7:0] F_WE   = 8'h01;
    localparam logic [7:0] F_WR   = F_BUSY | F_EN | F_WE;
    localparam logic [7:0] F_RD   = F_RDY | F_EN;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [7:0]   cfg_ctrl = '0;
    logic [W-1:0] cfg_min = '0;
    logic [W-1:0] cfg_max = '0;
    logic [W-1:0] cfg_cmp_0 = '0;
    logic [W-1:0] cfg_cmp_1 = '0;
    logic         stop_req = 1'b0;
    logic         busy;
    logic         cfg_done;
    logic         cfg_error;
    logic         cmp_0_event;
    logic         cmp_1_event;
    logic         enable;
    logic         write_enable;
    logic [3:0]   address;
    logic [W-1:0] write_data;
    logic [W-1:0] read_data = '0;

    typedef struct {
        logic [7:0]   ctrl;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
        logic [W-1:0] c0;
        logic [W-1:0] c1;
    } cfg_t;

    typedef struct {
        string        name;
        logic         r;
        logic         cv;
        logic         sr;
        int           cs;
        logic [W-1:0] rd;
        logic [7:0]   f;
        logic [3:0]   ad;
        logic [W-1:0] wd;
    } vec_t;

    typedef struct {
        string         name;
        logic [OW-1:0] exp;
    } sb_t;

    cfg_t cfgs[4];
    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    timer_sequencer #(.COUNTER_BIT_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ctrl(cfg_ctrl),
        .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_cmp_0(cfg_cmp_0), .cfg_cmp_1(cfg_cmp_1),
        .stop_req(stop_req), .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .cmp_0_event(cmp_0_event), .cmp_1_event(cmp_1_event),
        .enable(enable), .write_enable(write_enable), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic r, input logic cv, input logic sr,
                                input int cs, input logic [W-1:0] rd, input logic [7:0] f,
                                input logic [3:0] ad, input logic [W-1:0] wd);
        vecs.push_back('{n, r, cv, sr, cs, rd, f, ad, wd});
    endfunction

    task automatic apply(input vec_t v);
        sb_t e;
        @(posedge clk);
        #1;
        rst       = v.r;
        cfg_valid = v.cv;
        stop_req  = v.sr;
        cfg_ctrl  = cfgs[v.cs].ctrl;
        cfg_min   = cfgs[v.cs].mn;
        cfg_max   = cfgs[v.cs].mx;
        cfg_cmp_0 = cfgs[v.cs].c0;
        cfg_cmp_1 = cfgs[v.cs].c1;
        read_data = v.rd;
        e.name = v.name;
        e.exp  = {v.f, v.ad, v.wd};
        sb.push_back(e);
    endtask

    // Outputs are compared on the falling edge, half a cycle from any update.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            logic [OW-1:0] act;
            e = sb.pop_front();
            act = {cfg_ready, busy, cfg_done, cfg_error, cmp_1_event, cmp_0_event,
                   enable, write_enable, address, write_data};
            check(e.name, 64'(act), 64'(e.exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        cfgs[0] = '{8'hC2, 12'h010, 12'h0F0, 12'h040, 12'h080};
        cfgs[1] = '{8'h42, 12'h080, 12'h080, 12'h011, 12'h022};
        cfgs[2] = '{8'h42, 12'h001, 12'h020, 12'h005, 12'h006};
        cfgs[3] = '{8'h8F, 12'h100, 12'hFFF, 12'h123, 12'hABC};

        //   name            r  cv sr cs rd       flags          ad  wd
        add("rst0",          1, 0, 0, 0, 12'h000, 8'h00,         0,  12'h000);
        add("rst1",          1, 0, 0, 0, 12'h000, 8'h00,         0,  12'h000);
        add("idle_accept",   0, 1, 0, 0, 12'h000, F_RDY,         0,  12'h000);
        add("wr_ctrl_stop",  0, 0, 0, 0, 12'h000, F_WR,          0,  12'h0C2);
        add("wr_min",        0, 0, 0, 0, 12'h000, F_WR,          5,  12'h010);
        add("wr_max",        0, 0, 0, 0, 12'h000, F_WR,          6,  12'h0F0);
        add("wr_cmp0",       0, 0, 0, 0, 12'h000, F_WR,          4,  12'h040);
        add("wr_cmp1",       0, 0, 0, 0, 12'h000, F_WR,          3,  12'h080);
        add("wr_ctrl_start", 0, 0, 0, 0, 12'h000, F_WR,          0,  12'h0CA);
        add("done",          0, 0, 0, 0, 12'h000, F_RD | F_DONE, 1,  12'h000);
        add("mon_low_bits",  0, 0, 0, 0, 12'h03F, F_RD,          1,  12'h000);
        add("mon_flag1",     0, 0, 0, 0, 12'h080, F_RD,          1,  12'h000);
        add("clear_cmp1",    0, 0, 0, 0, 12'h0C0, F_WR | F_E1,   1,  12'h080);
        add("mon_reconf",    0, 1, 0, 2, 12'h0C0, F_RD,          1,  12'h000);
        add("re_wr_ctrl",    0, 0, 0, 2, 12'h000, F_WR,          0,  12'h042);
        add("re_wr_min",     0, 0, 0, 2, 12'h000, F_WR,          5,  12'h001);
        add("re_wr_max",     0, 0, 0, 2, 12'h000, F_WR,          6,  12'h020);
        add("re_wr_cmp0",    0, 0, 0, 2, 12'h000, F_WR,          4,  12'h005);
        add("re_wr_cmp1",    0, 0, 0, 2, 12'h000, F_WR,          3,  12'h006);
        add("re_wr_start",   0, 0, 0, 2, 12'h000, F_WR,          0,  12'h04A);
        add("done2",         0, 0, 0, 2, 12'h0C0, F_RD | F_DONE, 1,  12'h000);
        add("clear_cmp0",    0, 0, 0, 2, 12'h000, F_WR | F_E0,   1,  12'h040);
        add("stop_all",      0, 1, 1, 3, 12'h0C0, F_EN,          1,  12'h000);
        add("stop_wr_ctrl",  0, 0, 0, 3, 12'h0C0, F_WR,          0,  12'h042);
        add("stop_idle",     0, 1, 0, 1, 12'h000, F_RDY,         0,  12'h000);
        add("bad_error",     0, 0, 0, 1, 12'h000, F_RDY | F_ERR, 0,  12'h000);
        add("idle_stopreq",  0, 1, 1, 3, 12'h000, 8'h00,         0,  12'h000);
        add("idle_accept3",  0, 1, 0, 3, 12'h000, F_RDY,         0,  12'h000);
        add("wr_ctrl3",      0, 0, 0, 3, 12'h000, F_WR,          0,  12'h087);
        add("wr_min3",       0, 0, 0, 3, 12'h000, F_WR,          5,  12'h100);
        add("rst_in_max",    1, 0, 0, 3, 12'h000, F_WR,          6,  12'hFFF);
        add("rst_out",       0, 0, 0, 3, 12'h000, F_RDY,         0,  12'h000);
        add("idle_accept3b", 0, 1, 0, 3, 12'h000, F_RDY,         0,  12'h000);
        add("wr_ctrl3b",     0, 0, 0, 3, 12'h000, F_WR,          0,  12'h087);
        add("wr_min3b",      0, 0, 0, 3, 12'h000, F_WR,          5,  12'h100);
        add("wr_max3b",      0, 0, 0, 3, 12'h000, F_WR,          6,  12'hFFF);
        add("wr_cmp03b",     0, 0, 0, 3, 12'h000, F_WR,          4,  12'h123);
        add("wr_cmp13b",     0, 0, 0, 3, 12'h000, F_WR,          3,  12'hABC);
        add("wr_start3b",    0, 0, 0, 3, 12'h000, F_WR,          0,  12'h08F);
        add("done3_masked",  0, 0, 0, 3, 12'h040, F_RD | F_DONE, 1,  12'h000);
        add("mon_flag_hi",   0, 0, 0, 3, 12'hFC0, F_RD,          1,  12'h000);
        add("clear_cmp1b",   0, 0, 0, 3, 12'h000, F_WR | F_E1,   1,  12'h080);
        add("mon_stop",      0, 0, 1, 3, 12'h000, F_EN,          1,  12'h000);
        add("stop3",         0, 0, 0, 3, 12'h000, F_WR,          0,  12'h087);
        add("idle_end",      0, 0, 0, 3, 12'h000, F_RDY,         0,  12'h000);

        foreach (vecs[i]) apply(vecs[i]);
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Boundary min = max - 1 is legal; cfg_done arrives seven cycles after accept.
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_ctrl  = 8'h40;
        cfg_min   = 12'h07F;
        cfg_max   = 12'h080;
        cfg_cmp_0 = 12'h001;
        cfg_cmp_1 = 12'h002;
        read_data = '0;
        @(negedge clk);
        check("hand_ready", 64'(cfg_ready), 64'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cfg_done) begin
                n = i;
                break;
            end
        end
        check("done_latency", 64'(n), 64'd7);

        // Invalid request (min > max) accepted in MONITOR: error, drop flags, back to IDLE.
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_min   = 12'h081;
        cfg_max   = 12'h080;
        read_data = 12'h0C0;
        @(negedge clk);
        check("mon_bad_ready", 64'(cfg_ready), 64'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        read_data = '0;
        @(negedge clk);
        check("mon_bad_error", 64'({cfg_error, enable, busy, cmp_0_event, cmp_1_event}), 64'b10000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mon_bad_idle", 64'({cfg_error, enable, busy, cfg_ready}), 64'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
